// File: rtl/aes_core_arbiter_if.sv
// aes_core_arbiter_if
//   Bundles the two requester channels and the AES core channel that the
//   arbiter sits between.
//   master modport : the arbiter's view (drives grants, done flags, result
//                    and all core-side controls).
//   slave modport  : the environment's view (requesters plus the AES core).
//   Signals:
//     REQ0/REQ1, KEY0/KEY1, MSG0/MSG1 : requester request level, key, ciphertext
//     GNT0/GNT1, DONE0/DONE1, RESULT  : grant, result-valid, registered plaintext
//     CORE_START, CORE_KEY, CORE_MSG  : level start and registered core inputs
//     CORE_DONE, CORE_RESULT          : core completion level and output state
//     CORE_RESET                      : one-cycle core reset on watchdog abort
//     TIMEOUT_ERR                     : sticky watchdog error flag
interface aes_core_arbiter_if #(
    parameter int DATA_W = 128
);
    logic              REQ0;
    logic              REQ1;
    logic [DATA_W-1:0] KEY0;
    logic [DATA_W-1:0] KEY1;
    logic [DATA_W-1:0] MSG0;
    logic [DATA_W-1:0] MSG1;
    logic              GNT0;
    logic              GNT1;
    logic              DONE0;
    logic              DONE1;
    logic [DATA_W-1:0] RESULT;
    logic              CORE_START;
    logic [DATA_W-1:0] CORE_KEY;
    logic [DATA_W-1:0] CORE_MSG;
    logic              CORE_DONE;
    logic [DATA_W-1:0] CORE_RESULT;
    logic              CORE_RESET;
    logic              TIMEOUT_ERR;

    modport master (
        input  REQ0, REQ1, KEY0, KEY1, MSG0, MSG1, CORE_DONE, CORE_RESULT,
        output GNT0, GNT1, DONE0, DONE1, RESULT, CORE_START, CORE_KEY,
               CORE_MSG, CORE_RESET, TIMEOUT_ERR
    );

    modport slave (
        output REQ0, REQ1, KEY0, KEY1, MSG0, MSG1, CORE_DONE, CORE_RESULT,
        input  GNT0, GNT1, DONE0, DONE1, RESULT, CORE_START, CORE_KEY,
               CORE_MSG, CORE_RESET, TIMEOUT_ERR
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one AES decryption core between requester 0 (software/bus) and
//   requester 1 (hardware stream engine). Latches the winner's key and
//   ciphertext, sequences the core's level START/DONE handshake, returns the
//   registered plaintext, and aborts a hung core with a watchdog.
//   Ports:
//     CLK      : system clock
//     RESET_N  : asynchronous active-low reset (also resets the core)
//     bus      : aes_core_arbiter_if.master, requester and core channels
//   Parameters:
//     DATA_W      : key / message / result width
//     TIMEOUT_CYC : RUN cycles without CORE_DONE before abort (>= 1)
//   Build option:
//     AES_ARB_FIXED_PRIO_EN : when defined, requester 0 always wins a tie;
//                             otherwise ties alternate round-robin.
module aes_core_arbiter #(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               CLK,
    input  logic               RESET_N,
    aes_core_arbiter_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, GRANT, RUN, HOLD, RELEASE} state_t;

    state_t            state, state_nxt;
    logic              sel, sel_nxt;
    logic              last_served, last_served_nxt;
    logic              abandon, abandon_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              gnt0, gnt0_nxt, gnt1, gnt1_nxt;
    logic              done0, done0_nxt, done1, done1_nxt;
    logic              core_start, core_start_nxt;
    logic              core_reset, core_reset_nxt;
    logic              timeout_err, timeout_err_nxt;
    logic [DATA_W-1:0] result, result_nxt;
    logic [DATA_W-1:0] core_key, core_key_nxt;
    logic [DATA_W-1:0] core_msg, core_msg_nxt;

    logic              tie_pick;
    logic              pick;
    logic              req_sel;
    logic              abandon_now;
    logic [WD_W-1:0]   wd_inc;

`ifdef AES_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = ~last_served;
`endif

    // A lone request wins outright; only a tie consults the priority rule.
    assign pick        = (bus.REQ0 && bus.REQ1) ? tie_pick : bus.REQ1;
    assign req_sel     = sel ? bus.REQ1 : bus.REQ0;
    // A request dropped on the very cycle the core finishes still abandons.
    assign abandon_now = abandon | ~req_sel;
    assign wd_inc      = wd + WD_W'(1);

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        last_served_nxt = last_served;
        abandon_nxt     = abandon;
        wd_nxt          = wd;
        gnt0_nxt        = gnt0;
        gnt1_nxt        = gnt1;
        done0_nxt       = done0;
        done1_nxt       = done1;
        core_start_nxt  = core_start;
        core_reset_nxt  = 1'b0;
        timeout_err_nxt = timeout_err;
        result_nxt      = result;
        core_key_nxt    = core_key;
        core_msg_nxt    = core_msg;

        unique case (state)
            IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    sel_nxt         = pick;
                    last_served_nxt = pick;
                    gnt0_nxt        = ~pick;
                    gnt1_nxt        = pick;
                    core_key_nxt    = pick ? bus.KEY1 : bus.KEY0;
                    core_msg_nxt    = pick ? bus.MSG1 : bus.MSG0;
                    state_nxt       = GRANT;
                end
            end
            GRANT: begin
                core_start_nxt = 1'b1;
                wd_nxt         = '0;
                if (!req_sel) begin
                    abandon_nxt = 1'b1;
                end
                state_nxt = RUN;
            end
            RUN: begin
                wd_nxt      = wd_inc;
                abandon_nxt = abandon_now;
                // CORE_DONE takes precedence over a coincident terminal count.
                if (bus.CORE_DONE) begin
                    result_nxt = bus.CORE_RESULT;
                    if (!abandon_now) begin
                        done0_nxt = ~sel;
                        done1_nxt = sel;
                        state_nxt = HOLD;
                    end else begin
                        core_start_nxt = 1'b0;
                        gnt0_nxt       = 1'b0;
                        gnt1_nxt       = 1'b0;
                        state_nxt      = RELEASE;
                    end
                end else if (wd_inc == WD_W'(TIMEOUT_CYC)) begin
                    timeout_err_nxt = 1'b1;
                    core_reset_nxt  = 1'b1;
                    core_start_nxt  = 1'b0;
                    gnt0_nxt        = 1'b0;
                    gnt1_nxt        = 1'b0;
                    state_nxt       = RELEASE;
                end
            end
            HOLD: begin
                // START stays high so the core holds its DONE state until the
                // requester has consumed the result.
                if (!req_sel) begin
                    core_start_nxt = 1'b0;
                    gnt0_nxt       = 1'b0;
                    gnt1_nxt       = 1'b0;
                    done0_nxt      = 1'b0;
                    done1_nxt      = 1'b0;
                    state_nxt      = RELEASE;
                end
            end
            RELEASE: begin
                core_start_nxt = 1'b0;
                gnt0_nxt       = 1'b0;
                gnt1_nxt       = 1'b0;
                done0_nxt      = 1'b0;
                done1_nxt      = 1'b0;
                abandon_nxt    = 1'b0;
                // Wait for the core to leave DONE before offering a new grant.
                if (!bus.CORE_DONE) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            sel         <= 1'b0;
            last_served <= 1'b1;
            abandon     <= 1'b0;
            wd          <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            core_start  <= 1'b0;
            core_reset  <= 1'b0;
            timeout_err <= 1'b0;
            result      <= '0;
            core_key    <= '0;
            core_msg    <= '0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            last_served <= last_served_nxt;
            abandon     <= abandon_nxt;
            wd          <= wd_nxt;
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            done0       <= done0_nxt;
            done1       <= done1_nxt;
            core_start  <= core_start_nxt;
            core_reset  <= core_reset_nxt;
            timeout_err <= timeout_err_nxt;
            result      <= result_nxt;
            core_key    <= core_key_nxt;
            core_msg    <= core_msg_nxt;
        end
    end

    assign bus.GNT0        = gnt0;
    assign bus.GNT1        = gnt1;
    assign bus.DONE0       = done0;
    assign bus.DONE1       = done1;
    assign bus.RESULT      = result;
    assign bus.CORE_START  = core_start;
    assign bus.CORE_KEY    = core_key;
    assign bus.CORE_MSG    = core_msg;
    assign bus.CORE_RESET  = core_reset;
    assign bus.TIMEOUT_ERR = timeout_err;
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter
//   Directed bench for aes_core_arbiter. Instance a uses the default watchdog
//   with a responsive core model; instance b uses TIMEOUT_CYC=16 and a core
//   model that can be told to hang.
module tb_aes_core_arbiter;
    logic clk;
    logic rst_n;

    aes_core_arbiter_if #(.DATA_W(128)) ia ();
    aes_core_arbiter_if #(.DATA_W(128)) ib ();

    aes_core_arbiter #(.DATA_W(128)) u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .bus(ia)
    );
    aes_core_arbiter #(.DATA_W(128), .TIMEOUT_CYC(16)) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int lat_a = 5;
    int lat_b = 3;
    bit hang_b = 1'b1;
    int cnt_a;
    int cnt_b;

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] m);
        return k ^ {m[63:0], m[127:64]} ^ 128'h5A5A_1234_0F0F_9876_C3C3_2468_ACE0_1357;
    endfunction

    // Core models: DONE rises after lat START-high cycles and holds until START drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= 0;
            ia.CORE_DONE <= 1'b0;
            ia.CORE_RESULT <= '0;
        end else if (!ia.CORE_START) begin
            cnt_a <= 0;
            ia.CORE_DONE <= 1'b0;
        end else if (!ia.CORE_DONE) begin
            if (cnt_a == lat_a - 1) begin
                ia.CORE_DONE <= 1'b1;
                ia.CORE_RESULT <= core_fn(ia.CORE_KEY, ia.CORE_MSG);
            end else begin
                cnt_a <= cnt_a + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_b <= 0;
            ib.CORE_DONE <= 1'b0;
            ib.CORE_RESULT <= '0;
        end else if (!ib.CORE_START || ib.CORE_RESET) begin
            cnt_b <= 0;
            ib.CORE_DONE <= 1'b0;
        end else if (!ib.CORE_DONE) begin
            if (!hang_b && cnt_b == lat_b - 1) begin
                ib.CORE_DONE <= 1'b1;
                ib.CORE_RESULT <= core_fn(ib.CORE_KEY, ib.CORE_MSG);
            end else begin
                cnt_b <= cnt_b + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    function automatic logic sig_a(input int s);
        case (s)
            0: return ia.GNT0;
            1: return ia.GNT1;
            2: return ia.DONE0;
            3: return ia.DONE1;
            default: return ia.CORE_DONE;
        endcase
    endfunction

    // Bounded wait on an instance-a signal; expiry is reported as a failure.
    task automatic wait_a(input int s, input string nm);
        bit seen;
        int c;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 120) begin
            @(negedge clk);
            seen = sig_a(s);
            c++;
        end
        chk_b({nm, " seen"}, seen, 1'b1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        bit r0;
        bit r1;
        bit exp_w;
    } vec_t;

    vec_t tbl[9];
    logic [127:0] k0, m0, k1, m1;
    int cnt;
    bit d1;
    bit seen;

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
`ifdef AES_ARB_FIXED_PRIO_EN
        tbl = '{'{1,1,0}, '{1,1,0}, '{1,1,0}, '{1,1,0}, '{1,1,0}, '{1,1,0},
                '{0,1,1}, '{1,0,0}, '{1,1,0}};
`else
        tbl = '{'{1,1,0}, '{1,1,1}, '{1,1,0}, '{1,1,1}, '{1,1,0}, '{1,1,1},
                '{0,1,1}, '{1,0,0}, '{1,1,1}};
`endif
        ia.REQ0 = 0; ia.REQ1 = 0; ia.KEY0 = '0; ia.KEY1 = '0; ia.MSG0 = '0; ia.MSG1 = '0;
        ib.REQ0 = 0; ib.REQ1 = 0; ib.KEY0 = '0; ib.KEY1 = '0; ib.MSG0 = '0; ib.MSG1 = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk_b("rst gnt0", ia.GNT0, 1'b0);
        chk_b("rst gnt1", ia.GNT1, 1'b0);
        chk_b("rst done0", ia.DONE0, 1'b0);
        chk_b("rst done1", ia.DONE1, 1'b0);
        chk_b("rst core_start", ia.CORE_START, 1'b0);
        chk_b("rst core_reset", ia.CORE_RESET, 1'b0);
        chk_b("rst timeout_err", ia.TIMEOUT_ERR, 1'b0);
        chk("rst result", ia.RESULT, '0);
        chk("rst core_key", ia.CORE_KEY, '0);
        chk("rst core_msg", ia.CORE_MSG, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Arbitration table: both requesters re-request after each service.
        for (int i = 0; i < 9; i++) begin
            k0 = {4{32'hA000_0000 | 32'(i)}};
            m0 = {4{32'hB000_0000 | 32'(i)}};
            k1 = {4{32'hC000_0000 | 32'(i)}};
            m1 = {4{32'hD000_0000 | 32'(i)}};
            ia.KEY0 = k0; ia.MSG0 = m0; ia.KEY1 = k1; ia.MSG1 = m1;
            ia.REQ0 = tbl[i].r0;
            ia.REQ1 = tbl[i].r1;
            @(negedge clk);
            chk_b($sformatf("row%0d gnt0", i), ia.GNT0, ~tbl[i].exp_w);
            chk_b($sformatf("row%0d gnt1", i), ia.GNT1, tbl[i].exp_w);
            chk($sformatf("row%0d core_key", i), ia.CORE_KEY, tbl[i].exp_w ? k1 : k0);
            chk($sformatf("row%0d core_msg", i), ia.CORE_MSG, tbl[i].exp_w ? m1 : m0);
            wait_a(2 + int'(tbl[i].exp_w), $sformatf("row%0d done", i));
            chk($sformatf("row%0d result", i), ia.RESULT,
                tbl[i].exp_w ? core_fn(k1, m1) : core_fn(k0, m0));
            ia.REQ0 = 0;
            ia.REQ1 = 0;
            settle();
        end

        // REQ0 alone with a 40-cycle core.
        lat_a = 40;
        k0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        m0 = 128'h69C4_E0D8_6A7B_0430_D8CD_B780_70B4_C55A;
        ia.KEY0 = k0; ia.MSG0 = m0; ia.REQ0 = 1;
        @(negedge clk);
        chk_b("t1 gnt0", ia.GNT0, 1'b1);
        chk_b("t1 gnt1", ia.GNT1, 1'b0);
        chk_b("t1 start in grant", ia.CORE_START, 1'b0);
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (ia.CORE_DONE) seen = 1'b1;
            else if (ia.CORE_START) cnt++;
        end
        chk("t1 start cycles", 128'(cnt), 128'd40);
        chk_b("t1 done0 not early", ia.DONE0, 1'b0);
        @(negedge clk);
        chk_b("t1 done0", ia.DONE0, 1'b1);
        chk("t1 result", ia.RESULT, core_fn(k0, m0));
        @(negedge clk);
        chk_b("t1 hold start", ia.CORE_START, 1'b1);
        chk_b("t1 hold done0", ia.DONE0, 1'b1);
        ia.REQ0 = 0;
        @(negedge clk);
        chk_b("t1 rel gnt0", ia.GNT0, 1'b0);
        chk_b("t1 rel done0", ia.DONE0, 1'b0);
        chk_b("t1 rel start", ia.CORE_START, 1'b0);
        settle();

        // REQ1 abandons 10 cycles into RUN while REQ0 waits.
        lat_a = 20;
        k1 = {4{32'h1111_2222}}; m1 = {4{32'h3333_4444}};
        k0 = {4{32'h5555_6666}}; m0 = {4{32'h7777_8888}};
        ia.KEY1 = k1; ia.MSG1 = m1; ia.REQ1 = 1;
        @(negedge clk);
        chk_b("t3 gnt1", ia.GNT1, 1'b1);
        ia.KEY0 = k0; ia.MSG0 = m0; ia.REQ0 = 1;
        repeat (11) @(negedge clk);
        ia.REQ1 = 0;
        d1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            d1 = d1 | ia.DONE1;
            seen = ia.CORE_DONE;
        end
        chk_b("t3 core_done seen", seen, 1'b1);
        chk_b("t3 start held to done", ia.CORE_START, 1'b1);
        @(negedge clk);
        d1 = d1 | ia.DONE1;
        chk_b("t3 start dropped", ia.CORE_START, 1'b0);
        chk_b("t3 gnt1 dropped", ia.GNT1, 1'b0);
        chk_b("t3 no done1", d1, 1'b0);
        chk("t3 result loaded", ia.RESULT, core_fn(k1, m1));
        wait_a(0, "t3 gnt0");
        chk_b("t3 gnt1 off", ia.GNT1, 1'b0);
        chk("t3 core_key", ia.CORE_KEY, k0);
        wait_a(2, "t3 done0");
        chk("t3 result0", ia.RESULT, core_fn(k0, m0));
        ia.REQ0 = 0;
        settle();

        // Key/message change after grant must not reach the core.
        lat_a = 8;
        k0 = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
        m0 = 128'h3AD7_7BB4_0D7A_3660_A89E_CAF3_2466_EF97;
        ia.KEY0 = k0; ia.MSG0 = m0; ia.REQ0 = 1;
        @(negedge clk);
        chk_b("t6 gnt0", ia.GNT0, 1'b1);
        @(negedge clk);
        ia.KEY0 = '1; ia.MSG0 = '1;
        wait_a(2, "t6 done0");
        chk("t6 core_key", ia.CORE_KEY, k0);
        chk("t6 core_msg", ia.CORE_MSG, m0);
        chk("t6 result", ia.RESULT, core_fn(k0, m0));
        ia.REQ0 = 0;
        settle();

        // Watchdog abort on instance b (TIMEOUT_CYC=16, hung core).
        ib.KEY0 = {4{32'hDEAD_BEEF}}; ib.MSG0 = {4{32'hFEED_F00D}}; ib.REQ0 = 1;
        @(negedge clk);
        chk_b("t4 gnt0", ib.GNT0, 1'b1);
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (ib.TIMEOUT_ERR) seen = 1'b1;
            else if (ib.CORE_START) cnt++;
        end
        chk_b("t4 timeout_err", ib.TIMEOUT_ERR, 1'b1);
        chk("t4 run cycles", 128'(cnt), 128'd16);
        chk_b("t4 core_reset", ib.CORE_RESET, 1'b1);
        chk_b("t4 gnt0 dropped", ib.GNT0, 1'b0);
        chk_b("t4 no done0", ib.DONE0, 1'b0);
        chk_b("t4 start dropped", ib.CORE_START, 1'b0);
        @(negedge clk);
        chk_b("t4 core_reset pulse", ib.CORE_RESET, 1'b0);
        chk_b("t4 err sticky", ib.TIMEOUT_ERR, 1'b1);
        ib.REQ0 = 0;
        hang_b = 1'b0;
        settle();
        k0 = {4{32'h0BAD_CAFE}}; m0 = {4{32'h1234_5678}};
        ib.KEY0 = k0; ib.MSG0 = m0; ib.REQ0 = 1;
        @(negedge clk);
        chk_b("t4 regrant", ib.GNT0, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = ib.DONE0;
        end
        chk_b("t4 served done0", seen, 1'b1);
        chk("t4 served result", ib.RESULT, core_fn(k0, m0));
        chk_b("t4 err still set", ib.TIMEOUT_ERR, 1'b1);
        ib.REQ0 = 0;
        settle();

        // Asynchronous reset while in HOLD.
        lat_a = 5;
        k0 = {4{32'hCAFE_0001}}; m0 = {4{32'hCAFE_0002}};
        ia.KEY0 = k0; ia.MSG0 = m0; ia.REQ0 = 1;
        wait_a(2, "t5 done0");
        #2 rst_n = 1'b0;
        #1;
        chk_b("t5 gnt0", ia.GNT0, 1'b0);
        chk_b("t5 done0", ia.DONE0, 1'b0);
        chk_b("t5 start", ia.CORE_START, 1'b0);
        chk("t5 result", ia.RESULT, '0);
        chk("t5 core_key", ia.CORE_KEY, '0);
        chk_b("t5 b timeout_err", ib.TIMEOUT_ERR, 1'b0);
        ia.REQ0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        k1 = {4{32'hCAFE_0003}}; m1 = {4{32'hCAFE_0004}};
        ia.KEY1 = k1; ia.MSG1 = m1;
        ia.REQ0 = 1; ia.REQ1 = 1;
        @(negedge clk);
        chk_b("t5 post gnt0", ia.GNT0, 1'b1);
        chk_b("t5 post gnt1", ia.GNT1, 1'b0);
        wait_a(2, "t5 post done0");
        chk("t5 post result", ia.RESULT, core_fn(k0, m0));
        ia.REQ0 = 0; ia.REQ1 = 0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
